sdram_frame_arb: RTL and testbench

SDRAM_FRAME_ARB -- requirements
Module: sdram_frame_arb

---
 rtl/sdram_frame_arb_if.sv | 22 ++
 rtl/sdram_frame_arb.sv | 203 ++++++++++++++++++++
 tb/tb_sdram_frame_arb.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_frame_arb_if.sv
// SDRAM controller burst handshake: request, start address and length per direction,
// with the controller's acknowledge held high for the burst data phase.
interface sdram_frame_arb_if;
  logic        sdram_wr_req;
  logic        sdram_rd_req;
  logic        sdram_wr_ack;
  logic        sdram_rd_ack;
  logic [21:0] sys_wraddr;
  logic [21:0] sys_rdaddr;
  logic [8:0]  sdwr_byte;
  logic [8:0]  sdrd_byte;

  modport master (
    output sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr, sdwr_byte, sdrd_byte,
    input  sdram_wr_ack, sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr, sdwr_byte, sdrd_byte,
    output sdram_wr_ack, sdram_rd_ack
  );
endinterface

// File: rtl/sdram_frame_arb.sv
// Frame-buffer SDRAM arbiter: round-robin write bursts from NCH video channels into
// ping-pong buffers, with priority display read bursts from the last completed frame.
module sdram_frame_arb #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned BURST       = 160,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter int unsigned REGION_W    = 17,
  parameter int unsigned LVL_W       = 10,
  parameter int unsigned RD_THRESH   = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*LVL_W-1:0]   wr_lvl,
  input  logic [NCH-1:0]         wr_fsync,
  input  logic [LVL_W-1:0]       rd_lvl,
  input  logic                   rd_fsync,
  input  logic [1:0]             rd_sel,
  sdram_frame_arb_if.master      sdram,
  output logic [NCH-1:0]         wr_grant,
  output logic                   busy
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER} state_t;

  state_t                          state_q, state_d;
  logic [NCH-1:0]                  wb_q, wb_d, db_q, db_d, pend_q, pend_d;
  logic [NCH-1:0][REGION_W-1:0]    wo_q, wo_d;
  logic                            rb_q, rb_d, rpend_q, rpend_d;
  logic [REGION_W-1:0]             ro_q, ro_d;
  logic [1:0]                      rch_q, rch_d, rr_q, rr_d, ch_q, ch_d;
  logic [21:0]                     wraddr_q, wraddr_d, rdaddr_q, rdaddr_d;
  logic [8:0]                      wrlen_q, wrlen_d, rdlen_q, rdlen_d;
  logic [1:0]                      sel_ch;
  logic                            wr_busy, rd_busy, found;
  int unsigned                     idx;

  function automatic logic [8:0] burst_len(input logic [REGION_W-1:0] off);
    int unsigned rem;
    rem = FRAME_WORDS - 32'(off);
    return (rem < BURST) ? 9'(rem) : 9'(BURST);
  endfunction

  function automatic logic [REGION_W-1:0] advance(input logic [REGION_W-1:0] off,
                                                  input logic [8:0] len);
    int unsigned sum;
    sum = 32'(off) + 32'(len);
    return (sum == FRAME_WORDS) ? '0 : REGION_W'(sum);
  endfunction

  function automatic logic [21:0] buf_addr(input int unsigned ch, input logic b,
                                           input logic [REGION_W-1:0] off);
    return 22'(((ch * 2 + 32'(b)) << REGION_W) + 32'(off));
  endfunction

  assign sel_ch = (32'(rd_sel) >= NCH) ? 2'd0 : rd_sel;

  always_comb begin
    state_d  = state_q;
    wb_d     = wb_q;
    db_d     = db_q;
    wo_d     = wo_q;
    pend_d   = pend_q;
    rb_d     = rb_q;
    ro_d     = ro_q;
    rch_d    = rch_q;
    rpend_d  = rpend_q;
    rr_d     = rr_q;
    ch_d     = ch_q;
    wraddr_d = wraddr_q;
    wrlen_d  = wrlen_q;
    rdaddr_d = rdaddr_q;
    rdlen_d  = rdlen_q;
    found    = 1'b0;
    idx      = 0;
    wr_busy  = (state_q == WR_REQ) || (state_q == WR_XFER);
    rd_busy  = (state_q == RD_REQ) || (state_q == RD_XFER);

    // Frame syncs are applied before the grant logic so a same-cycle grant sees them.
    if (rd_fsync) begin
      if (rd_busy) rpend_d = 1'b1;
      else begin
        rch_d = sel_ch;
        rb_d  = db_q[sel_ch];
        ro_d  = '0;
      end
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      if (wr_fsync[k]) begin
        if (wr_busy && ch_q == 2'(k)) pend_d[k] = 1'b1;
        else begin
          db_d[k] = wb_q[k];
          wb_d[k] = ~wb_q[k];
          wo_d[k] = '0;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (32'(rd_lvl) < RD_THRESH) begin
          state_d  = RD_REQ;
          rdaddr_d = buf_addr(32'(rch_d), rb_d, ro_d);
          rdlen_d  = burst_len(ro_d);
        end else begin
          for (int unsigned k = 0; k < NCH; k++) begin
            idx = (32'(rr_q) + k) % NCH;
            if (!found && 32'(wr_lvl[idx*LVL_W +: LVL_W]) >= 32'(burst_len(wo_d[idx]))) begin
              found    = 1'b1;
              state_d  = WR_REQ;
              ch_d     = 2'(idx);
              rr_d     = 2'((idx + 1) % NCH);
              wraddr_d = buf_addr(idx, wb_d[idx], wo_d[idx]);
              wrlen_d  = burst_len(wo_d[idx]);
            end
          end
        end
      end
      WR_REQ: if (sdram.sdram_wr_ack) state_d = WR_XFER;
      WR_XFER: begin
        if (!sdram.sdram_wr_ack) begin
          state_d = IDLE;
          // A deferred sync lands after the offset update, discarding the advanced offset.
          for (int unsigned k = 0; k < NCH; k++) begin
            if (ch_q == 2'(k)) begin
              wo_d[k] = advance(wo_q[k], wrlen_q);
              if (pend_q[k] || wr_fsync[k]) begin
                db_d[k]   = wb_q[k];
                wb_d[k]   = ~wb_q[k];
                wo_d[k]   = '0;
                pend_d[k] = 1'b0;
              end
            end
          end
        end
      end
      RD_REQ: if (sdram.sdram_rd_ack) state_d = RD_XFER;
      RD_XFER: begin
        if (!sdram.sdram_rd_ack) begin
          state_d = IDLE;
          ro_d    = advance(ro_q, rdlen_q);
          if (rpend_q || rd_fsync) begin
            rch_d   = sel_ch;
            rb_d    = db_q[sel_ch];
            ro_d    = '0;
            rpend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wb_q     <= '0;
      db_q     <= '0;
      wo_q     <= '0;
      pend_q   <= '0;
      rb_q     <= 1'b0;
      ro_q     <= '0;
      rch_q    <= '0;
      rpend_q  <= 1'b0;
      rr_q     <= '0;
      ch_q     <= '0;
      wraddr_q <= '0;
      wrlen_q  <= '0;
      rdaddr_q <= '0;
      rdlen_q  <= '0;
    end else begin
      state_q  <= state_d;
      wb_q     <= wb_d;
      db_q     <= db_d;
      wo_q     <= wo_d;
      pend_q   <= pend_d;
      rb_q     <= rb_d;
      ro_q     <= ro_d;
      rch_q    <= rch_d;
      rpend_q  <= rpend_d;
      rr_q     <= rr_d;
      ch_q     <= ch_d;
      wraddr_q <= wraddr_d;
      wrlen_q  <= wrlen_d;
      rdaddr_q <= rdaddr_d;
      rdlen_q  <= rdlen_d;
    end
  end

  assign sdram.sdram_wr_req = (state_q == WR_REQ);
  assign sdram.sdram_rd_req = (state_q == RD_REQ);
  assign sdram.sys_wraddr   = wraddr_q;
  assign sdram.sys_rdaddr   = rdaddr_q;
  assign sdram.sdwr_byte    = wrlen_q;
  assign sdram.sdrd_byte    = rdlen_q;
  assign busy               = (state_q != IDLE);

  always_comb begin
    wr_grant = '0;
    for (int unsigned k = 0; k < NCH; k++)
      wr_grant[k] = (state_q == WR_XFER) && (ch_q == 2'(k));
  end

endmodule

// File: tb/tb_sdram_frame_arb.sv
// Directed bench for sdram_frame_arb: a transaction-rule model of the arbiter checked
// every cycle, plus literal expectations at the interesting burst boundaries.
module tb_sdram_frame_arb;
  localparam int FW = 76700;
  localparam int BL = 160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] wr_lvl;
  logic [1:0]  wr_fsync;
  logic [9:0]  rd_lvl;
  logic        rd_fsync;
  logic [1:0]  rd_sel;
  logic [1:0]  wr_grant;
  logic        busy;

  sdram_frame_arb_if ifc();

  sdram_frame_arb #(.NCH(2), .BURST(BL), .FRAME_WORDS(FW), .REGION_W(17),
                    .LVL_W(10), .RD_THRESH(256)) dut (
    .clk(clk), .rst_n(rst_n), .wr_lvl(wr_lvl), .wr_fsync(wr_fsync),
    .rd_lvl(rd_lvl), .rd_fsync(rd_fsync), .rd_sel(rd_sel), .sdram(ifc.master),
    .wr_grant(wr_grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Controller responder: raise ack one cycle after a request, hold it for a set length.
  logic wack_r = 1'b0, rack_r = 1'b0, wack_f = 1'b0, rack_f = 1'b0;
  int   wcnt = 0, rcnt = 0, wack_len = 160, rack_len = 10;
  assign ifc.sdram_wr_ack = wack_r | wack_f;
  assign ifc.sdram_rd_ack = rack_r | rack_f;

  always @(negedge clk) begin
    if (!rst_n) begin
      wack_r = 1'b0; rack_r = 1'b0; wcnt = 0; rcnt = 0;
    end else begin
      if (wcnt != 0) begin wcnt--; if (wcnt == 0) wack_r = 1'b0; end
      else if (ifc.sdram_wr_req && !wack_r) begin wack_r = 1'b1; wcnt = wack_len; end
      if (rcnt != 0) begin rcnt--; if (rcnt == 0) rack_r = 1'b0; end
      else if (ifc.sdram_rd_req && !rack_r) begin rack_r = 1'b1; rcnt = rack_len; end
    end
  end

  // Model: phase 0 idle, 1 write requested, 2 write data, 3 read requested, 4 read data.
  int m_ph, m_g, m_rr, m_wlen, m_rlen, m_waddr, m_raddr, m_rch, m_rb, m_ro, m_rp;
  int m_wb[2], m_db[2], m_wo[2], m_wp[2];

  function automatic int blen(input int off);
    return (FW - off < BL) ? FW - off : BL;
  endfunction
  function automatic int region(input int c, input int b, input int off);
    return ((c * 2 + b) << 17) + off;
  endfunction

  task automatic wsync(input int c);
    m_db[c] = m_wb[c]; m_wb[c] = 1 - m_wb[c]; m_wo[c] = 0;
  endtask
  task automatic rsync();
    m_rch = (rd_sel >= 2) ? 0 : int'(rd_sel); m_rb = m_db[m_rch]; m_ro = 0;
  endtask

  task automatic model_reset();
    m_ph = 0; m_g = 0; m_rr = 0; m_wlen = 0; m_rlen = 0; m_waddr = 0; m_raddr = 0;
    m_rch = 0; m_rb = 0; m_ro = 0; m_rp = 0;
    for (int c = 0; c < 2; c++) begin m_wb[c] = 0; m_db[c] = 0; m_wo[c] = 0; m_wp[c] = 0; end
  endtask

  task automatic model_step();
    bit hit = 0;
    if (rd_fsync) begin if (m_ph >= 3) m_rp = 1; else rsync(); end
    for (int c = 0; c < 2; c++)
      if (wr_fsync[c]) begin
        if ((m_ph == 1 || m_ph == 2) && m_g == c) m_wp[c] = 1; else wsync(c);
      end
    case (m_ph)
      0: if (rd_lvl < 256) begin
           m_ph = 3; m_raddr = region(m_rch, m_rb, m_ro); m_rlen = blen(m_ro);
         end else
           for (int k = 0; k < 2; k++) begin
             int c = (m_rr + k) % 2;
             if (!hit && int'(wr_lvl[c*10 +: 10]) >= blen(m_wo[c])) begin
               hit = 1; m_ph = 1; m_g = c; m_rr = (c + 1) % 2;
               m_waddr = region(c, m_wb[c], m_wo[c]); m_wlen = blen(m_wo[c]);
             end
           end
      1: if (ifc.sdram_wr_ack) m_ph = 2;
      2: if (!ifc.sdram_wr_ack) begin
           m_wo[m_g] = (m_wo[m_g] + m_wlen) % FW;
           if (m_wp[m_g] != 0) begin wsync(m_g); m_wp[m_g] = 0; end
           m_ph = 0;
         end
      3: if (ifc.sdram_rd_ack) m_ph = 4;
      4: if (!ifc.sdram_rd_ack) begin
           m_ro = (m_ro + m_rlen) % FW;
           if (m_rp != 0) begin rsync(); m_rp = 0; end
           m_ph = 0;
         end
      default: m_ph = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_ph != 0));
    chk("wr_req", int'(ifc.sdram_wr_req), int'(m_ph == 1));
    chk("rd_req", int'(ifc.sdram_rd_req), int'(m_ph == 3));
    chk("wr_grant", int'(wr_grant), (m_ph == 2) ? (1 << m_g) : 0);
    if (m_ph == 1 || m_ph == 2) begin
      chk("sys_wraddr", int'(ifc.sys_wraddr), m_waddr);
      chk("sdwr_byte", int'(ifc.sdwr_byte), m_wlen);
    end
    if (m_ph >= 3) begin
      chk("sys_rdaddr", int'(ifc.sys_rdaddr), m_raddr);
      chk("sdrd_byte", int'(ifc.sdrd_byte), m_rlen);
    end
  end

  function automatic int sig(input int w);
    case (w)
      0:       return int'(busy);
      1:       return int'(ifc.sdram_wr_req);
      default: return int'(ifc.sdram_rd_req);
    endcase
  endfunction

  task automatic wait_sig(input int w, input int val, input string nm);
    int n = 0;
    while (sig(w) != val && n < 2000) begin @(negedge clk); n++; end
    chk(nm, sig(w), val);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lvl(input int l0, input int l1);
    wr_lvl = {10'(l1), 10'(l0)};
  endtask

  initial begin
    rst_n = 1'b0; set_lvl(200, 0); wr_fsync = '0; rd_lvl = 10'd300; rd_fsync = 1'b0; rd_sel = '0;
    step(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wraddr", int'(ifc.sys_wraddr), 0);
    chk("rst_wrbyte", int'(ifc.sdwr_byte), 0);
    rst_n = 1'b1;

    // First grant on the first edge after release: ch0, address 0, full burst.
    @(negedge clk);
    chk("first_wr_req", int'(ifc.sdram_wr_req), 1);
    chk("first_wraddr", int'(ifc.sys_wraddr), 0);
    chk("first_wrbyte", int'(ifc.sdwr_byte), 160);
    step(10);
    chk("grant_ch0", int'(wr_grant), 1);
    set_lvl(0, 0);
    wait_sig(0, 0, "burst1_done");
    wack_len = 4;
    set_lvl(200, 0);
    wait_sig(1, 1, "burst2_req");
    chk("wo0_after_burst", int'(ifc.sys_wraddr), 160);
    set_lvl(0, 0);
    wait_sig(0, 0, "burst2_done");

    // Both channels ready: round-robin continues from ch1.
    set_lvl(500, 500);
    wait_sig(1, 1, "rr1_req");
    chk("rr1_ch1_addr", int'(ifc.sys_wraddr), 'h40000);
    wait_sig(0, 0, "rr1_done");
    wait_sig(1, 1, "rr2_req");
    chk("rr2_ch0_addr", int'(ifc.sys_wraddr), 320);
    wait_sig(0, 0, "rr2_done");
    wait_sig(1, 1, "rr3_req");
    chk("rr3_ch1_addr", int'(ifc.sys_wraddr), 'h400A0);
    set_lvl(0, 0);
    wait_sig(0, 0, "rr3_done");

    // March ch0 up to the end of the frame: short tail burst, then wrap to 0.
    wack_len = 1;
    set_lvl(500, 0);
    for (int i = 0; i < 476; i++) begin
      wait_sig(1, 1, "march_req");
      wait_sig(0, 0, "march_done");
    end
    wait_sig(1, 1, "tail_req");
    chk("tail_addr", int'(ifc.sys_wraddr), 76640);
    chk("tail_len", int'(ifc.sdwr_byte), 60);
    wait_sig(0, 0, "tail_done");
    wait_sig(1, 1, "wrap_req");
    chk("wrap_addr", int'(ifc.sys_wraddr), 0);
    chk("wrap_len", int'(ifc.sdwr_byte), 160);
    set_lvl(159, 0);
    wait_sig(0, 0, "wrap_done");
    step(5);
    chk("lvl_below_len_idle", int'(busy), 0);
    set_lvl(160, 0);
    wait_sig(1, 1, "lvl_eq_len_req");
    chk("lvl_eq_len_addr", int'(ifc.sys_wraddr), 160);
    set_lvl(0, 0);
    wait_sig(0, 0, "lvl_eq_done");

    // Frame sync mid-burst deferred to burst end; second pulse ignored.
    wack_len = 20;
    set_lvl(500, 0);
    wait_sig(1, 1, "sync_burst_req");
    step(5);
    wr_fsync = 2'b01; step(1); wr_fsync = '0; set_lvl(0, 0);
    step(3);
    wr_fsync = 2'b01; step(1); wr_fsync = '0;
    wait_sig(0, 0, "sync_burst_done");
    set_lvl(500, 0);
    wait_sig(1, 1, "post_sync_req");
    chk("post_sync_addr", int'(ifc.sys_wraddr), 'h20000);
    set_lvl(0, 0);
    wait_sig(0, 0, "post_sync_done");

    // Sync and grant for ch1 in the same cycle: grant sees the flipped buffer at offset 0.
    wr_fsync = 2'b10; set_lvl(0, 500);
    @(negedge clk);
    wr_fsync = '0;
    chk("sync_grant_req", int'(ifc.sdram_wr_req), 1);
    chk("sync_grant_addr", int'(ifc.sys_wraddr), 'h60000);
    set_lvl(0, 0);
    wait_sig(0, 0, "sync_grant_done");

    // Display: rd_sel=3 maps to ch0; read wins over pending write data.
    wr_fsync = 2'b01; step(1); wr_fsync = '0;
    rd_sel = 2'd3; rd_fsync = 1'b1; step(1); rd_fsync = 1'b0;
    rd_lvl = 10'd100; set_lvl(500, 0);
    wait_sig(2, 1, "rd_req");
    chk("rd_wins", int'(ifc.sdram_wr_req), 0);
    chk("rd_addr", int'(ifc.sys_rdaddr), 'h20000);
    chk("rd_len", int'(ifc.sdrd_byte), 160);
    step(4);
    rd_sel = 2'd1; rd_fsync = 1'b1; step(1); rd_fsync = 1'b0;
    wait_sig(0, 0, "rd1_done");
    wait_sig(2, 1, "rd2_req");
    chk("rd_deferred_addr", int'(ifc.sys_rdaddr), 'h40000);
    rd_lvl = 10'd300;
    wait_sig(0, 0, "rd2_done");
    wait_sig(1, 1, "wr_after_rd_req");
    chk("wr_after_rd_addr", int'(ifc.sys_wraddr), 0);
    set_lvl(0, 0);
    wait_sig(0, 0, "wr_after_rd_done");

    // Acks outside a burst are ignored.
    wack_f = 1'b1; rack_f = 1'b1;
    step(3);
    chk("stray_ack_idle", int'(busy), 0);
    wack_f = 1'b0; rack_f = 1'b0;
    step(2);

    // Asynchronous reset in the middle of a write data phase.
    wack_len = 50;
    set_lvl(200, 0);
    wait_sig(1, 1, "pre_rst_req");
    step(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_grant", int'(wr_grant), 0);
    chk("arst_wr_req", int'(ifc.sdram_wr_req), 0);
    chk("arst_wraddr", int'(ifc.sys_wraddr), 0);
    chk("arst_wrbyte", int'(ifc.sdwr_byte), 0);
    set_lvl(0, 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_idle", int'(busy), 0);
    set_lvl(500, 500);
    wait_sig(1, 1, "post_rst_req");
    chk("post_rst_addr", int'(ifc.sys_wraddr), 0);
    chk("post_rst_len", int'(ifc.sdwr_byte), 160);
    set_lvl(0, 0);
    wait_sig(0, 0, "post_rst_done");
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
